// File: rtl/root_fanin_pkg.sv
// Shared parameters for the root fan-in collector and its round-robin arbiter.
package root_fanin_pkg;
    localparam int N_CH_DEF  = 5;
    localparam int DW_DEF    = 8;
    localparam int CNT_W_DEF = 16;
    // Width of a channel index (out_src, cnt_sel, arbiter pointer); supports up to 8 channels.
    localparam int IDX_W     = 3;
endpackage

// File: rtl/root_fanin_collector_rr_arbiter.sv
// Round-robin arbiter: the first requester at or above ptr (mod N_CH) wins.
// Purely combinational, so the grant settles in the same cycle as the request.
module rr_arbiter
    import root_fanin_pkg::*;
#(
    parameter int N_CH = N_CH_DEF
) (
    input  logic [N_CH-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_CH-1:0]  gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             gnt_vld_o
);

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        // Walk offsets from farthest to nearest so the nearest requester is the last one written.
        for (int k = N_CH - 1; k >= 0; k--) begin
            int idx;
            idx = int'(ptr_i) + k;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            if (req_i[idx]) begin
                gnt_o      = '0;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = IDX_W'(idx);
                gnt_vld_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/root_fanin_collector.sv
// Merges N_CH valid/ready child channels into one output register, round-robin.
// Accept-to-out_valid latency is one cycle; a stalled output holds its word and blocks all inputs.
module root_fanin_collector
    import root_fanin_pkg::*;
#(
    parameter int N_CH  = N_CH_DEF,
    parameter int DW    = DW_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CH-1:0]      in_valid,
    input  logic [N_CH*DW-1:0]   in_data,
    output logic [N_CH-1:0]      in_ready,
    output logic                 out_valid,
    output logic [DW-1:0]        out_data,
    output logic [IDX_W-1:0]     out_src,
    input  logic                 out_ready,
    input  logic [IDX_W-1:0]     cnt_sel,
    output logic [CNT_W-1:0]     cnt_val
);

    logic               out_valid_q;
    logic [DW-1:0]      out_data_q;
    logic [IDX_W-1:0]   out_src_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   ptr_d;
    logic [CNT_W-1:0]   cnt_q [N_CH];

    logic [N_CH-1:0]    gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_vld;
    logic               slot_free;
    logic               accept;
    logic [DW-1:0]      sel_data;

    rr_arbiter #(
        .N_CH (N_CH)
    ) u_arb (
        .req_i     (in_valid),
        .ptr_i     (ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .gnt_vld_o (gnt_vld)
    );

    assign slot_free = !out_valid_q || out_ready;
    assign in_ready  = (!rst && slot_free) ? gnt : '0;
    assign accept    = !rst && slot_free && gnt_vld;
    assign ptr_d     = (gnt_idx == IDX_W'(N_CH - 1)) ? '0 : gnt_idx + IDX_W'(1);

    // Only the granted channel's data ever reaches the output register.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (gnt_idx == IDX_W'(i)) begin
                sel_data = in_data[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            ptr_q       <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= sel_data;
            out_src_q   <= gnt_idx;
            ptr_q       <= ptr_d;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (in_ready[i] && in_valid[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        cnt_val = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (cnt_sel == IDX_W'(i)) begin
                cnt_val = cnt_q[i];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule
